// File: rtl/galaga_pkg.sv
// galaga_pkg: types and constants shared by the sprite scheduler, the blitter and the
// VGA controller.
//   sprite_entry_t : one sprite table entry {active, id, x, y}
//   sched_state_t  : frame scheduler FSM state encoding
package galaga_pkg;

    localparam int unsigned COORD_W = 10;  // x/y coordinate width (640x480 space)
    localparam int unsigned ID_W    = 4;   // sprite bitmap id width

    typedef struct packed {
        logic               active;
        logic [ID_W-1:0]    id;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StClear    = 3'd1,
        StFetch    = 3'd2,
        StWaitRd   = 3'd3,
        StIssue    = 3'd4,
        StWaitDone = 3'd5,
        StNext     = 3'd6,
        StSwap     = 3'd7
    } sched_state_t;

endpackage

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-frame controller for the sprite-draw datapath.
// On each vsync start it clears the back buffer, walks the sprite table, sends one draw
// command per active sprite to the blitter (valid/ready), then swaps front/back buffers.
// Ports:
//   CLOCK_50, RESET_N          clock, async active-low reset
//   vsync_n                    VGA vertical sync (low = pulse); falling edge starts a frame
//   tbl_rd_en/tbl_addr         sprite table read strobe/address
//   tbl_rd_data                table entry, valid one cycle after tbl_rd_en
//   fb_clear_req/fb_clear_done back-buffer clear handshake
//   blit_valid/blit_ready      draw command handshake carrying blit_x/blit_y/blit_id
//   blit_done                  pulse: accepted command fully drawn
//   buffer_sel                 displayed buffer; back buffer is ~buffer_sel
//   frame_busy                 frame in progress
//   frame_overrun/overrun_clr  sticky "vsync while busy" flag and its clear
//   draw_count                 sprites drawn in the last completed frame
module sprite_scheduler
    import galaga_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_SPRITES),
    parameter int unsigned COORD_W     = galaga_pkg::COORD_W,
    parameter int unsigned ID_W        = galaga_pkg::ID_W
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               vsync_n,
    output logic               tbl_rd_en,
    output logic [IDX_W-1:0]   tbl_addr,
    input  sprite_entry_t      tbl_rd_data,
    output logic               fb_clear_req,
    input  logic               fb_clear_done,
    output logic               blit_valid,
    input  logic               blit_ready,
    output logic [COORD_W-1:0] blit_x,
    output logic [COORD_W-1:0] blit_y,
    output logic [ID_W-1:0]    blit_id,
    input  logic               blit_done,
    output logic               buffer_sel,
    output logic               frame_busy,
    output logic               frame_overrun,
    input  logic               overrun_clr,
    output logic [IDX_W:0]     draw_count
);

    localparam logic [IDX_W-1:0] LastSlot = IDX_W'(NUM_SPRITES - 1);

    sched_state_t   state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    sprite_entry_t  entry_q, entry_d;
    logic [IDX_W:0] run_cnt_q, run_cnt_d;
    logic [IDX_W:0] draw_count_q, draw_count_d;
    logic           buffer_sel_q, buffer_sel_d;
    logic           overrun_q, overrun_d;
    logic           vsync_q;
    logic           start_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            entry_q      <= '0;
            run_cnt_q    <= '0;
            draw_count_q <= '0;
            buffer_sel_q <= 1'b0;
            overrun_q    <= 1'b0;
            // Idle level of vsync_n, so a low input out of reset is not an edge.
            vsync_q      <= 1'b1;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            entry_q      <= entry_d;
            run_cnt_q    <= run_cnt_d;
            draw_count_q <= draw_count_d;
            buffer_sel_q <= buffer_sel_d;
            overrun_q    <= overrun_d;
            vsync_q      <= vsync_n;
            start_q      <= vsync_q & ~vsync_n;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        entry_d      = entry_q;
        run_cnt_d    = run_cnt_q;
        draw_count_d = draw_count_q;
        buffer_sel_d = buffer_sel_q;
        overrun_d    = overrun_q;

        tbl_rd_en    = 1'b0;
        fb_clear_req = 1'b0;
        blit_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_q) begin
                    run_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                fb_clear_req = 1'b1;
                if (fb_clear_done) begin
                    slot_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                tbl_rd_en = 1'b1;
                state_d   = StWaitRd;
            end
            StWaitRd: begin
                entry_d = tbl_rd_data;
                state_d = tbl_rd_data.active ? StIssue : StNext;
            end
            StIssue: begin
                blit_valid = 1'b1;
                if (blit_ready) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (blit_done) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                    state_d   = StNext;
                end
            end
            StNext: begin
                if (slot_q == LastSlot) begin
                    state_d = StSwap;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StSwap: begin
                buffer_sel_d = ~buffer_sel_q;
                draw_count_d = run_cnt_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A start outside IDLE (SWAP included) is dropped and only flagged; clear wins.
        if (start_q && (state_q != StIdle)) overrun_d = 1'b1;
        if (overrun_clr) overrun_d = 1'b0;
    end

    assign tbl_addr      = slot_q;
    assign blit_x        = entry_q.x;
    assign blit_y        = entry_q.y;
    assign blit_id       = entry_q.id;
    assign buffer_sel    = buffer_sel_q;
    assign frame_busy    = (state_q != StIdle);
    assign frame_overrun = overrun_q;
    assign draw_count    = draw_count_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
module tb_sprite_scheduler;
    import galaga_pkg::*;

    localparam int NS = 16;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N = 1'b1;
    logic          vsync_n = 1'b1;
    logic          tbl_rd_en;
    logic [3:0]    tbl_addr;
    sprite_entry_t tbl_rd_data = '0;
    logic          fb_clear_req;
    logic          fb_clear_done = 1'b0;
    logic          blit_valid;
    logic          blit_ready = 1'b1;
    logic [9:0]    blit_x;
    logic [9:0]    blit_y;
    logic [3:0]    blit_id;
    logic          blit_done = 1'b0;
    logic          buffer_sel;
    logic          frame_busy;
    logic          frame_overrun;
    logic          overrun_clr = 1'b0;
    logic [4:0]    draw_count;

    sprite_entry_t tbl [NS];
    logic [23:0]   hs_q[$];
    logic [3:0]    rd_q[$];
    int hs_cnt = 0, done_cnt = 0, clear_cnt = 0, rd_cnt = 0, vld_cnt = 0, walk_cnt = 0;
    int done_delay = 5;
    int total = 0, bad = 0;
    int hs_b, rd_b, clr_b, vld_b, walk_b, done_b;

    localparam logic [23:0] Spr0 = {10'd100, 10'd200, 4'd2};
    localparam logic [23:0] Spr3 = {10'd300, 10'd50, 4'd7};

    sprite_scheduler #(.NUM_SPRITES(16), .IDX_W(4), .COORD_W(10), .ID_W(4)) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .vsync_n      (vsync_n),
        .tbl_rd_en    (tbl_rd_en),
        .tbl_addr     (tbl_addr),
        .tbl_rd_data  (tbl_rd_data),
        .fb_clear_req (fb_clear_req),
        .fb_clear_done(fb_clear_done),
        .blit_valid   (blit_valid),
        .blit_ready   (blit_ready),
        .blit_x       (blit_x),
        .blit_y       (blit_y),
        .blit_id      (blit_id),
        .blit_done    (blit_done),
        .buffer_sel   (buffer_sel),
        .frame_busy   (frame_busy),
        .frame_overrun(frame_overrun),
        .overrun_clr  (overrun_clr),
        .draw_count   (draw_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous table: data one cycle after the strobe, junk (active=1) otherwise.
    initial forever begin
        logic       pend;
        logic [3:0] a;
        @(negedge CLOCK_50);
        pend = (tbl_rd_en === 1'b1);
        a = tbl_addr;
        if (pend) begin rd_q.push_back(a); rd_cnt++; end
        if (blit_valid === 1'b1) vld_cnt++;
        if (frame_busy === 1'b1 && fb_clear_req === 1'b0) walk_cnt++;
        @(posedge CLOCK_50);
        #1 tbl_rd_data = pend ? tbl[a] : '1;
    end

    // Clear responder: done pulse a couple of cycles after the request.
    initial forever begin
        @(negedge CLOCK_50);
        if (fb_clear_req === 1'b1) begin
            clear_cnt++;
            repeat (2) @(posedge CLOCK_50);
            #1 fb_clear_done = 1'b1;
            @(posedge CLOCK_50);
            #1 fb_clear_done = 1'b0;
        end
    end

    // Blitter: record each accepted command, pulse done done_delay cycles after accept.
    initial forever begin
        @(negedge CLOCK_50);
        if (blit_valid === 1'b1 && blit_ready === 1'b1) begin
            hs_q.push_back({blit_x, blit_y, blit_id});
            hs_cnt++;
            repeat (done_delay + 1) @(posedge CLOCK_50);
            #1 blit_done = 1'b1;
            done_cnt++;
            @(posedge CLOCK_50);
            #1 blit_done = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLOCK_50); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] hs_at(input int i);
        return (i < hs_q.size()) ? hs_q[i] : 24'hFFFFFF;
    endfunction

    function automatic logic [3:0] rd_at(input int i);
        return (i < rd_q.size()) ? rd_q[i] : 4'hF;
    endfunction

    task automatic wait_busy(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (frame_busy !== lvl && n < bound) begin tick(1); n++; end
        chk({tag, " wait"}, {31'd0, frame_busy === lvl}, 32'd1);
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n = 0;
        while (hs_cnt < target && n < 200) begin tick(1); n++; end
        chk({tag, " hs wait"}, {31'd0, hs_cnt >= target}, 32'd1);
    endtask

    task automatic frame_start(input string tag);
        vsync_n = 1'b0;
        wait_busy(1'b1, 10, tag);
        vsync_n = 1'b1;
    endtask

    task automatic snap();
        hs_b = hs_cnt; rd_b = rd_cnt; clr_b = clear_cnt;
        vld_b = vld_cnt; walk_b = walk_cnt; done_b = done_cnt;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) tbl[i] = '0;

        // 1: asynchronous reset mid-cycle
        tick(2);
        #5 RESET_N = 1'b0;
        #1;
        chk("rst buffer_sel", {31'd0, buffer_sel}, 32'd0);
        chk("rst draw_count", {27'd0, draw_count}, 32'd0);
        chk("rst frame_busy", {31'd0, frame_busy}, 32'd0);
        chk("rst blit_valid", {31'd0, blit_valid}, 32'd0);
        chk("rst clear_req", {31'd0, fb_clear_req}, 32'd0);
        chk("rst rd_en", {31'd0, tbl_rd_en}, 32'd0);
        chk("rst overrun", {31'd0, frame_overrun}, 32'd0);
        chk("rst addr/xyid", {8'd0, blit_x, blit_y, blit_id}, {28'd0, tbl_addr});
        chk("rst tbl_addr", {28'd0, tbl_addr}, 32'd0);
        tick(2);
        RESET_N = 1'b1;
        tick(3);

        // 2: slots 0 and 3 active, ready always high
        tbl[0] = {1'b1, 4'd2, 10'd100, 10'd200};
        tbl[3] = {1'b1, 4'd7, 10'd300, 10'd50};
        done_delay = 5;
        snap();
        frame_start("f2 start");
        wait_busy(1'b0, 400, "f2 end");
        chk("f2 hs count", hs_cnt - hs_b, 32'd2);
        chk("f2 cmd0", {8'd0, hs_at(hs_b)}, {8'd0, Spr0});
        chk("f2 cmd1", {8'd0, hs_at(hs_b + 1)}, {8'd0, Spr3});
        chk("f2 draw_count", {27'd0, draw_count}, 32'd2);
        chk("f2 buffer_sel", {31'd0, buffer_sel}, 32'd1);
        chk("f2 clears", clear_cnt - clr_b, 32'd1);
        chk("f2 reads", rd_cnt - rd_b, 32'd16);
        chk("f2 first addr", {28'd0, rd_at(rd_b)}, 32'd0);
        chk("f2 valid idle", {31'd0, blit_valid}, 32'd0);
        tick(3);

        // 3: backpressure on the first command
        blit_ready = 1'b0;
        snap();
        frame_start("f3 start");
        begin
            int n = 0;
            while (blit_valid !== 1'b1 && n < 100) begin tick(1); n++; end
        end
        for (int i = 0; i < 10; i++) begin
            chk("f3 hold", {7'd0, blit_valid, blit_x, blit_y, blit_id}, {7'd0, 1'b1, Spr0});
            tick(1);
        end
        chk("f3 no accept", hs_cnt - hs_b, 32'd0);
        blit_ready = 1'b1;
        wait_busy(1'b0, 400, "f3 end");
        chk("f3 hs count", hs_cnt - hs_b, 32'd2);
        chk("f3 cmd0", {8'd0, hs_at(hs_b)}, {8'd0, Spr0});
        chk("f3 cmd1", {8'd0, hs_at(hs_b + 1)}, {8'd0, Spr3});
        chk("f3 draw_count", {27'd0, draw_count}, 32'd2);
        chk("f3 buffer_sel", {31'd0, buffer_sel}, 32'd0);
        tick(3);

        // 4: overrun during WAIT_DONE, then clear; then clear colliding with set
        done_delay = 20;
        snap();
        frame_start("f4 start");
        wait_hs(hs_b + 1, "f4");
        tick(2);
        vsync_n = 1'b0;
        tick(4);
        chk("f4 overrun set", {31'd0, frame_overrun}, 32'd1);
        chk("f4 still busy", {31'd0, frame_busy}, 32'd1);
        vsync_n = 1'b1;
        wait_busy(1'b0, 500, "f4 end");
        chk("f4 overrun sticky", {31'd0, frame_overrun}, 32'd1);
        chk("f4 hs count", hs_cnt - hs_b, 32'd2);
        chk("f4 draw_count", {27'd0, draw_count}, 32'd2);
        chk("f4 buffer_sel", {31'd0, buffer_sel}, 32'd1);
        tick(10);
        chk("f4 no restart", {31'd0, frame_busy}, 32'd0);
        chk("f4 one clear", clear_cnt - clr_b, 32'd1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("f4 overrun clr", {31'd0, frame_overrun}, 32'd0);
        done_delay = 5;
        frame_start("f4b start");
        tick(2);
        vsync_n = 1'b0;
        tick(1);
        overrun_clr = 1'b1;   // coincides with the edge where overrun would set
        tick(1);
        overrun_clr = 1'b0;
        chk("f4b clr wins", {31'd0, frame_overrun}, 32'd0);
        tick(3);
        chk("f4b stays clr", {31'd0, frame_overrun}, 32'd0);
        vsync_n = 1'b1;
        wait_busy(1'b0, 400, "f4b end");
        chk("f4b buffer_sel", {31'd0, buffer_sel}, 32'd0);
        tick(3);

        // 5: all slots inactive
        for (int i = 0; i < NS; i++) tbl[i] = '0;
        snap();
        frame_start("f5 start");
        wait_busy(1'b0, 400, "f5 end");
        chk("f5 walk cycles", walk_cnt - walk_b, 32'd49);
        chk("f5 no valid", vld_cnt - vld_b, 32'd0);
        chk("f5 no hs", hs_cnt - hs_b, 32'd0);
        chk("f5 reads", rd_cnt - rd_b, 32'd16);
        chk("f5 clears", clear_cnt - clr_b, 32'd1);
        chk("f5 draw_count", {27'd0, draw_count}, 32'd0);
        chk("f5 buffer_sel", {31'd0, buffer_sel}, 32'd1);
        tick(3);

        // 6: reset during WAIT_DONE, late done ignored, clean frame afterwards
        tbl[0] = {1'b1, 4'd2, 10'd100, 10'd200};
        tbl[3] = {1'b1, 4'd7, 10'd300, 10'd50};
        done_delay = 30;
        snap();
        frame_start("f6 start");
        wait_hs(hs_b + 1, "f6");
        tick(3);
        #5 RESET_N = 1'b0;
        #1;
        chk("f6 rst busy", {31'd0, frame_busy}, 32'd0);
        chk("f6 rst buffer_sel", {31'd0, buffer_sel}, 32'd0);
        chk("f6 rst draw_count", {27'd0, draw_count}, 32'd0);
        tick(2);
        RESET_N = 1'b1;
        begin
            int n = 0;
            while (done_cnt == done_b && n < 60) begin tick(1); n++; end
        end
        chk("f6 late done seen", {31'd0, done_cnt > done_b}, 32'd1);
        tick(2);
        chk("f6 idle busy", {31'd0, frame_busy}, 32'd0);
        chk("f6 idle valid", {31'd0, blit_valid}, 32'd0);
        chk("f6 idle rd_en", {31'd0, tbl_rd_en}, 32'd0);
        chk("f6 idle buffer_sel", {31'd0, buffer_sel}, 32'd0);
        done_delay = 5;
        snap();
        frame_start("f6b start");
        wait_busy(1'b0, 400, "f6b end");
        chk("f6b hs count", hs_cnt - hs_b, 32'd2);
        chk("f6b cmd0", {8'd0, hs_at(hs_b)}, {8'd0, Spr0});
        chk("f6b first addr", {28'd0, rd_at(rd_b)}, 32'd0);
        chk("f6b reads", rd_cnt - rd_b, 32'd16);
        chk("f6b draw_count", {27'd0, draw_count}, 32'd2);
        chk("f6b buffer_sel", {31'd0, buffer_sel}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
